// File: rtl/spi_arb_pkg.sv
// Shared types and sizing helpers for the SPI transmit arbiter.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        LOAD,
        ISSUE,
        WAIT_DONE,
        CS_HOLD
    } arb_state_t;

    // Width of the CS framing counter; never narrower than one bit.
    function automatic int cnt_width(input int setup_cycles, input int hold_cycles);
        int m;
        m = (setup_cycles > hold_cycles) ? setup_cycles : hold_cycles;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/spi_tx_arbiter_rr_picker.sv
// Combinational round-robin select: first valid index at or after ptr, wrapping.
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          found
);

    int j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!found && valid[j]) begin
                found     = 1'b1;
                idx       = IW'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one byte-wide SPI controller;
// owns the panel chip select and D/C lines and paces bytes on spi_done.
module spi_tx_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int CS_SETUP_CYCLES = 2,
    parameter int CS_HOLD_CYCLES  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_dc,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 spi_start,
    output logic [7:0]           spi_data,
    input  logic                 spi_busy,
    input  logic                 spi_done,
    output logic                 tft_cs,
    output logic                 tft_dc
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = cnt_width(CS_SETUP_CYCLES, CS_HOLD_CYCLES);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               cs_q, cs_d;
    logic               dc_q, dc_d;
    logic               last_q, last_d;
    logic [7:0]         data_q, data_d;
    logic               release_pkt;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IW-1:0]      pick_idx;
    logic               pick_found;

    rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
        .valid  (req_valid),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        cs_d        = cs_q;
        dc_d        = dc_q;
        last_d      = last_q;
        data_d      = data_q;
        release_pkt = 1'b0;
        req_ready   = '0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_onehot;
                    gidx_d  = pick_idx;
                    cs_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = (CS_SETUP_CYCLES > 0) ? CS_SETUP : LOAD;
                end
            end
            CS_SETUP: begin
                if (cnt_q == CW'(CS_SETUP_CYCLES - 1)) state_d = LOAD;
                else                                  cnt_d   = cnt_q + CW'(1);
            end
            LOAD: begin
                // The grant stays locked here; other requesters are ignored.
                if (!spi_busy) begin
                    req_ready = grant_q;
                    if (req_valid[gidx_q]) begin
                        data_d  = req_data[8*int'(gidx_q) +: 8];
                        dc_d    = req_dc[gidx_q];
                        last_d  = req_last[gidx_q];
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (spi_done) begin
                    if (!last_q) begin
                        state_d = LOAD;
                    end else if (CS_HOLD_CYCLES > 0) begin
                        state_d = CS_HOLD;
                        cnt_d   = '0;
                    end else begin
                        release_pkt = 1'b1;
                    end
                end
            end
            CS_HOLD: begin
                if (cnt_q == CW'(CS_HOLD_CYCLES - 1)) release_pkt = 1'b1;
                else                                 cnt_d       = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase

        if (release_pkt) begin
            cs_d    = 1'b1;
            grant_d = '0;
            ptr_d   = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            cs_q    <= 1'b1;
            dc_q    <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            dc_q    <= dc_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign grant     = grant_q;
    assign spi_start = (state_q == ISSUE);
    assign spi_data  = data_q;
    assign tft_cs    = cs_q;
    assign tft_dc    = dc_q;

endmodule
